score_bcd_accum: RTL

SCORE_BCD_ACCUM -- requirements
Module: score_bcd_accum

---
 rtl/score_bcd_accum_pkg.sv | 18 +
 rtl/bcd_digit_add.sv | 24 ++
 rtl/score_bcd_accum.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/score_bcd_accum_pkg.sv
// Shared definitions for the score accumulator: FSM states, BCD digit width
// and the points-per-apple rule.
package score_bcd_accum_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_CMP  = 2'd2
  } state_t;

  // Tens digit added per apple: 2*speed+1, i.e. 10/30/50/70 points.
  function automatic logic [BCD_W-1:0] points_tens(input logic [1:0] speed);
    return {1'b0, speed, 1'b1};
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with carry in/out.
module bcd_digit_add
  import score_bcd_accum_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  logic [BCD_W:0] raw;

  always_comb begin
    raw  = {1'b0, a} + {1'b0, b} + {{BCD_W{1'b0}}, cin};
    sum  = raw[BCD_W-1:0];
    cout = 1'b0;
    if (raw > (BCD_W+1)'(9)) begin
      sum  = BCD_W'(raw - (BCD_W+1)'(10));
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/score_bcd_accum.sv
// BCD score accumulator: adds apple points one digit per cycle through a
// shared digit adder, tracks the high score, queues one pending apple.
module score_bcd_accum
  import score_bcd_accum_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int SPEED_W = 2
) (
  input  logic                      clk_mode,
  input  logic                      rst,
  input  logic                      apple_valid,
  input  logic [SPEED_W-1:0]        speed,
  input  logic                      score_zero,
  output logic [BCD_W*DIGITS-1:0]   score_bcd,
  output logic [BCD_W*DIGITS-1:0]   high_bcd,
  output logic                      busy,
  output logic                      new_high,
  output logic                      saturated,
  output logic                      dropped
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t             state_q, state_nx;
  logic [IDX_W-1:0]   idx_q, idx_nx;
  logic               carry_q, carry_nx;
  logic [BCD_W-1:0]   addend_q, addend_nx;
  logic [W-1:0]       score_q, score_nx;
  logic [W-1:0]       high_q, high_nx;
  logic               sat_q, sat_nx;
  logic               pend_q, pend_nx;
  logic [1:0]         pend_spd_q, pend_spd_nx;
  logic               new_high_q, new_high_nx;
  logic               dropped_q, dropped_nx;

  logic [1:0]         speed_ext;
  logic [BCD_W-1:0]   dig_a, dig_b, dig_sum;
  logic               dig_cout;

  assign speed_ext = 2'(speed);
  assign dig_a     = score_q[int'(idx_q)*BCD_W +: BCD_W];
  // Only digit 1 receives the addend; higher digits see just the carry.
  assign dig_b     = (idx_q == IDX_ONE) ? addend_q : '0;

  bcd_digit_add u_digit_add (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  always_comb begin
    state_nx    = state_q;
    idx_nx      = idx_q;
    carry_nx    = carry_q;
    addend_nx   = addend_q;
    score_nx    = score_q;
    high_nx     = high_q;
    sat_nx      = sat_q;
    pend_nx     = pend_q;
    pend_spd_nx = pend_spd_q;
    new_high_nx = 1'b0;
    dropped_nx  = 1'b0;

    if (score_zero) begin
      score_nx = '0;
      sat_nx   = 1'b0;
      pend_nx  = 1'b0;
      carry_nx = 1'b0;
      state_nx = ST_IDLE;
    end else begin
      if (state_q != ST_IDLE && apple_valid) begin
        if (pend_q) begin
          dropped_nx = 1'b1;
        end else begin
          pend_nx     = 1'b1;
          pend_spd_nx = speed_ext;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (pend_q) begin
            addend_nx = points_tens(pend_spd_q);
            idx_nx    = IDX_ONE;
            carry_nx  = 1'b0;
            state_nx  = ST_ADD;
            // A fresh apple arriving while the pending one starts takes its slot.
            pend_nx   = apple_valid;
            if (apple_valid) pend_spd_nx = speed_ext;
          end else if (apple_valid) begin
            addend_nx = points_tens(speed_ext);
            idx_nx    = IDX_ONE;
            carry_nx  = 1'b0;
            state_nx  = ST_ADD;
          end
        end
        ST_ADD: begin
          score_nx[int'(idx_q)*BCD_W +: BCD_W] = dig_sum;
          carry_nx = dig_cout;
          if (idx_q == IDX_LAST) begin
            if (dig_cout) begin
              score_nx = {DIGITS{4'h9}};
              sat_nx   = 1'b1;
            end
            state_nx = ST_CMP;
          end else if (!dig_cout) begin
            state_nx = ST_CMP;
          end else begin
            idx_nx = idx_q + IDX_W'(1);
          end
        end
        ST_CMP: begin
          // Valid BCD orders the same as plain unsigned binary.
          if (score_q > high_q) begin
            high_nx     = score_q;
            new_high_nx = 1'b1;
          end
          state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_mode) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      addend_q   <= '0;
      score_q    <= '0;
      high_q     <= '0;
      sat_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_spd_q <= '0;
      new_high_q <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_nx;
      idx_q      <= idx_nx;
      carry_q    <= carry_nx;
      addend_q   <= addend_nx;
      score_q    <= score_nx;
      high_q     <= high_nx;
      sat_q      <= sat_nx;
      pend_q     <= pend_nx;
      pend_spd_q <= pend_spd_nx;
      new_high_q <= new_high_nx;
      dropped_q  <= dropped_nx;
    end
  end

  assign score_bcd = score_q;
  assign high_bcd  = high_q;
  assign busy      = (state_q != ST_IDLE);
  assign new_high  = new_high_q;
  assign saturated = sat_q;
  assign dropped   = dropped_q;

endmodule
